// File: rtl/seq_pkg.sv
// Shared definitions for the LED sequencer: playback FSM encoding and memory geometry.
package seq_pkg;

  localparam int SEQ_DEPTH = 8;
  localparam int SEQ_AW    = 3;
  localparam int SEQ_DW    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/seq_play_ctrl.sv
// Pattern memory controller: records entries, loops playback one entry per tick.
// Tick-to-leds latency 3 clk; ticks during a fetch are dropped (pulsed), records beyond DEPTH are refused.
module seq_play_ctrl
  import seq_pkg::*;
#(
  parameter int ADDR_WIDTH = SEQ_AW,
  parameter int DATA_WIDTH = SEQ_DW,
  parameter int DEPTH      = SEQ_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rec_pulse,
  input  logic [DATA_WIDTH-1:0] rec_data,
  input  logic                  clear_pulse,
  input  logic                  play_en,
  input  logic                  tick,
  output logic                  mem_w_en,
  output logic [ADDR_WIDTH-1:0] mem_w_addr,
  output logic [DATA_WIDTH-1:0] mem_w_data,
  output logic                  mem_r_en,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  input  logic [DATA_WIDTH-1:0] mem_r_data,
  output logic [DATA_WIDTH-1:0] leds,
  output logic [ADDR_WIDTH:0]   num_seqs,
  output logic                  full,
  output logic                  dropped
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ONE_CNT  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  seq_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] play_ptr;
  logic                  rec_ok;

  assign full   = (num_seqs == FULL_CNT);
  assign rec_ok = rec_pulse && !full && !clear_pulse && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_r_en   = 1'b0;
    mem_r_addr = play_ptr;
    mem_w_en   = rec_ok;
    mem_w_addr = w_ptr;
    mem_w_data = rec_data;
    dropped    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && play_en && (num_seqs != '0)) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        mem_r_en = 1'b1;
        dropped  = tick;
        state_d  = WAIT;
      end
      WAIT: begin
        dropped = tick;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Clear wins over everything, including a fetch already underway.
    if (clear_pulse || rst) begin
      state_d = IDLE;
      dropped = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_pulse) begin
      w_ptr    <= '0;
      play_ptr <= '0;
      num_seqs <= '0;
      leds     <= '0;
    end else begin
      if (rec_ok) begin
        num_seqs <= num_seqs + ONE_CNT;
        // Saturate: once the last slot is written, full blocks further records.
        if (w_ptr != LAST_PTR) begin
          w_ptr <= w_ptr + 1'b1;
        end
      end
      if (state_q == WAIT) begin
        leds     <= mem_r_data;
        play_ptr <= ({1'b0, play_ptr} == (num_seqs - ONE_CNT)) ? '0 : play_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_play_ctrl.sv
// Directed bench for seq_play_ctrl with a behavioural 1-cycle-read BRAM.
module tb_seq_play_ctrl;
  import seq_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              rec_pulse;
  logic [SEQ_DW-1:0] rec_data;
  logic              clear_pulse;
  logic              play_en;
  logic              tick;
  logic              mem_w_en;
  logic [SEQ_AW-1:0] mem_w_addr;
  logic [SEQ_DW-1:0] mem_w_data;
  logic              mem_r_en;
  logic [SEQ_AW-1:0] mem_r_addr;
  logic [SEQ_DW-1:0] mem_r_data;
  logic [SEQ_DW-1:0] leds;
  logic [SEQ_AW:0]   num_seqs;
  logic              full;
  logic              dropped;

  int n_cmp = 0;
  int n_bad = 0;

  logic [SEQ_DW-1:0] mem [SEQ_DEPTH];

  seq_play_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .rec_pulse   (rec_pulse),
    .rec_data    (rec_data),
    .clear_pulse (clear_pulse),
    .play_en     (play_en),
    .tick        (tick),
    .mem_w_en    (mem_w_en),
    .mem_w_addr  (mem_w_addr),
    .mem_w_data  (mem_w_data),
    .mem_r_en    (mem_r_en),
    .mem_r_addr  (mem_r_addr),
    .mem_r_data  (mem_r_data),
    .leds        (leds),
    .num_seqs    (num_seqs),
    .full        (full),
    .dropped     (dropped)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
    if (mem_r_en) mem_r_data <= mem[mem_r_addr];
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rec(input logic [1:0] d, input logic exp_en, input logic [2:0] exp_addr);
    rec_pulse = 1'b1;
    rec_data  = d;
    #1;
    chk("rec_w_en", 32'(mem_w_en), 32'(exp_en));
    chk("rec_w_addr", 32'(mem_w_addr), 32'(exp_addr));
    chk("rec_w_data", 32'(mem_w_data), 32'(d));
    @(posedge clk);
    #1;
    rec_pulse = 1'b0;
  endtask

  task automatic play(input logic [2:0] addr, input logic [1:0] old_l, input logic [1:0] new_l);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("fetch_r_en", 32'(mem_r_en), 32'd1);
    chk("fetch_r_addr", 32'(mem_r_addr), 32'(addr));
    step(1);
    chk("wait_r_en", 32'(mem_r_en), 32'd0);
    chk("leds_before", 32'(leds), 32'(old_l));
    step(1);
    chk("leds_after", 32'(leds), 32'(new_l));
    step(17);
  endtask

  initial begin
    rst = 1'b1; rec_pulse = 1'b0; rec_data = '0; clear_pulse = 1'b0;
    play_en = 1'b0; tick = 1'b0;
    step(2);
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_num", 32'(num_seqs), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_r_en", 32'(mem_r_en), 32'd0);
    chk("rst_w_en", 32'(mem_w_en), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    rst = 1'b0;
    step(1);

    // Record three entries
    rec(2'b01, 1'b1, 3'd0);
    rec(2'b10, 1'b1, 3'd1);
    rec(2'b11, 1'b1, 3'd2);
    chk("num3", 32'(num_seqs), 32'd3);
    chk("full3", 32'(full), 32'd0);

    // Looping playback with wrap 2 -> 0
    play_en = 1'b1;
    step(2);
    play(3'd0, 2'b00, 2'b01);
    play(3'd1, 2'b01, 2'b10);
    play(3'd2, 2'b10, 2'b11);
    play(3'd0, 2'b11, 2'b01);

    // Paused: tick ignored, leds hold, then resume from play_ptr=1
    play_en = 1'b0;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("pause_r_en", 32'(mem_r_en), 32'd0);
    step(3);
    chk("pause_leds", 32'(leds), 32'd1);
    play_en = 1'b1;
    play(3'd1, 2'b01, 2'b10);

    // Back-to-back ticks: second one lands in FETCH and is dropped
    tick = 1'b1;
    step(1);
    chk("drop_pulse", 32'(dropped), 32'd1);
    chk("drop_r_addr", 32'(mem_r_addr), 32'd2);
    step(1);
    tick = 1'b0;
    #1;
    chk("drop_clear", 32'(dropped), 32'd0);
    step(1);
    chk("drop_leds", 32'(leds), 32'd3);
    chk("drop_no_refetch", 32'(mem_r_en), 32'd0);
    step(4);
    chk("drop_leds_hold", 32'(leds), 32'd3);
    chk("drop_idle_r_en", 32'(mem_r_en), 32'd0);

    // Clear and record together during WAIT
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
    clear_pulse = 1'b1;
    rec_pulse = 1'b1;
    rec_data = 2'b10;
    #1;
    chk("clr_w_en", 32'(mem_w_en), 32'd0);
    step(1);
    clear_pulse = 1'b0;
    rec_pulse = 1'b0;
    chk("clr_num", 32'(num_seqs), 32'd0);
    chk("clr_leds", 32'(leds), 32'd0);
    chk("clr_full", 32'(full), 32'd0);
    chk("clr_r_en", 32'(mem_r_en), 32'd0);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("empty_r_en", 32'(mem_r_en), 32'd0);
    step(3);
    chk("empty_leds", 32'(leds), 32'd0);

    // Fill to DEPTH, then one refused record
    for (int i = 0; i < 9; i++) begin
      rec(2'((i + 1) % 4), (i < 8), 3'((i < 8) ? i : 7));
      if (i == 7) begin
        chk("full_at8", 32'(full), 32'd1);
        chk("num_at8", 32'(num_seqs), 32'd8);
      end
    end
    chk("num_after9", 32'(num_seqs), 32'd8);
    chk("full_after9", 32'(full), 32'd1);

    // Reset in the middle of a fetch of entry 0 (= 01)
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("rf_r_en", 32'(mem_r_en), 32'd1);
    chk("rf_r_addr", 32'(mem_r_addr), 32'd0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    #1;
    chk("rf_leds", 32'(leds), 32'd0);
    chk("rf_num", 32'(num_seqs), 32'd0);
    chk("rf_full", 32'(full), 32'd0);
    chk("rf_r_en_off", 32'(mem_r_en), 32'd0);
    chk("rf_w_en", 32'(mem_w_en), 32'd0);
    chk("rf_dropped", 32'(dropped), 32'd0);
    step(2);
    chk("rf_stale", 32'(leds), 32'd0);
    rec(2'b11, 1'b1, 3'd0);
    chk("rf_num1", 32'(num_seqs), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_play_ctrl.md
Name: seq_play_ctrl

Overview:
- Controller that sequences the 2-bit pattern memory (8-entry dual-port BRAM, 1-cycle registered read) of the LED sequencer.
- Owns the write pointer, the stored-entry count and the playback pointer.
- Issues BRAM write and read strobes and drives the LED register at each divided-clock tick.
- Sits between the debounced buttons / clock divider and the `memory` instance in the top level, replacing the ad-hoc pointer logic there.

Parameters:
- ADDR_WIDTH, 3, BRAM address width.
- DATA_WIDTH, 2, pattern width (one bit per LED).
- DEPTH, 8, number of storable entries; must equal 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock (12 MHz).
- rst  in  1  synchronous active-high reset.
- rec_pulse  in  1  one-cycle strobe: store rec_data as next entry.
- rec_data  in  DATA_WIDTH  pattern to store (level of pattern buttons).
- clear_pulse  in  1  one-cycle strobe: discard all entries.
- play_en  in  1  level: 1 = playback running, 0 = paused.
- tick  in  1  one-cycle strobe from the clock divider: advance playback.
- mem_w_en  out  1  BRAM write enable.
- mem_w_addr  out  ADDR_WIDTH  BRAM write address.
- mem_w_data  out  DATA_WIDTH  BRAM write data.
- mem_r_en  out  1  BRAM read enable.
- mem_r_addr  out  ADDR_WIDTH  BRAM read address.
- mem_r_data  in  DATA_WIDTH  BRAM read data, valid the cycle after mem_r_en.
- leds  out  DATA_WIDTH  registered LED pattern.
- num_seqs  out  ADDR_WIDTH+1  stored-entry count, 0..DEPTH.
- full  out  1  num_seqs == DEPTH.
- dropped  out  1  one-cycle pulse when a tick is ignored because a fetch is in flight.

Behaviour:
- Reset (rst=1 at a clk edge): all of the following are 0 on the next cycle.
  - leds, num_seqs, w_ptr, play_ptr, full, dropped, mem_w_en, mem_r_en.
  - State becomes IDLE.
  - Reset mid-fetch aborts the fetch; the returning mem_r_data is ignored.
- Recording: rec_pulse with !full and !clear_pulse:
  - Same cycle (combinational): mem_w_en=1, mem_w_addr=w_ptr, mem_w_data=rec_data.
  - Next cycle: w_ptr+1 and num_seqs+1.
  - rec_pulse while full: no write, counters unchanged. No overwrite and no wrap of w_ptr past DEPTH-1.
- Clear: clear_pulse has priority over rec_pulse and tick in the same cycle. Next cycle:
  - w_ptr=0, play_ptr=0, num_seqs=0, leds=0.
  - State IDLE; any in-flight fetch is abandoned.
- FSM states:
  - IDLE: on tick && play_en && num_seqs!=0 && !clear_pulse, go to FETCH. Tick with play_en=0 or num_seqs=0 is ignored, and leds hold.
  - FETCH (1 cycle): mem_r_en=1, mem_r_addr=play_ptr; go to WAIT.
  - WAIT (1 cycle): mem_r_data valid. leds<=mem_r_data. play_ptr <= (play_ptr == num_seqs-1) ? 0 : play_ptr+1, using num_seqs as sampled this cycle. Go to IDLE.
  - Latency: tick edge to leds update is 3 clk cycles (tick at N, leds valid at N+3).
- Tick arriving in FETCH or WAIT: ignored, dropped=1 for that cycle.
- play_en falling: the current fetch completes; afterwards leds hold and play_ptr holds. Resume continues from play_ptr.
- Record during playback:
  - Allowed in any state.
  - A write lands at w_ptr >= num_seqs > play_ptr, so no same-address read/write collision ever occurs.
  - A new entry joins the loop when play_ptr next reaches the old last index.
- num_seqs==0 with play_en=1: leds stay 0.
- Width rules:
  - num_seqs is ADDR_WIDTH+1 bits, so DEPTH is representable.
  - The num_seqs-1 compare is done at ADDR_WIDTH+1 bits.
  - Pointers are ADDR_WIDTH bits and never exceed DEPTH-1.
- mem_r_en is 0 outside FETCH. mem_w_en is 0 except on an accepted record.

Decomposition:
- Shared package seq_pkg holds:
  - the FSM state encoding: IDLE=2'd0, FETCH=2'd1, WAIT=2'd2;
  - the localparams SEQ_DEPTH=8, SEQ_AW=3, SEQ_DW=2, used by the top level, `memory` and this block.
- No sub-module. The BRAM (`memory`), debouncers and clock divider remain instantiated by the parent; this block is pure control.

Test Plan:
- Reset, then 3 rec_pulses with rec_data 01, 10, 11 -> writes at addr 0, 1, 2 with those data; num_seqs=3; full=0.
- With that content, play_en=1 and ticks every 20 cycles -> leds sequence 01, 10, 11, 01, ..., each update exactly 3 cycles after its tick; play_ptr wraps 2->0.
- 9 rec_pulses -> 8 writes at addr 0..7; full=1 after the 8th; 9th produces no mem_w_en; num_seqs=8.
- Tick one cycle after a previous tick (while in FETCH) -> dropped=1 for one cycle; exactly one leds update.
- clear_pulse and rec_pulse in the same cycle during WAIT -> no write; next cycle num_seqs=0, leds=0, state IDLE; following ticks leave leds=0.
- rst asserted during FETCH, then released -> all outputs 0; the stale mem_r_data does not reach leds; recording restarts at addr 0.
